// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the MEM-stage access sequencer
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } memseq_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/memseq_timeout_ctr.sv
// rtl/memseq_timeout_ctr.sv - saturating BUSY-cycle counter flagging the last allowed wait cycle
module memseq_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holds at LAST rather than wrapping, so expired stays asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - MEM-stage load/store sequencer with req/ack handshake, stall and timeout trap
module mem_access_sequencer
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite_M,
    input  logic [1:0]        ResultSrc_M,
    input  logic [ADDR_W-1:0] ALUResult_M,
    input  logic [DATA_W-1:0] WriteData_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] ReadData_M,
    output logic              Stall_Mem,
    output logic              Bubble_W,
    output logic              MemErr
);

    memseq_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              memerr_q, memerr_d;
    logic              access;
    logic              ctr_clear, ctr_en, ctr_expired;

    assign access = MemWrite_M | (ResultSrc_M == RESULT_SRC_LOAD);

    memseq_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (ctr_clear),
        .en_i     (ctr_en),
        .expired_o(ctr_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        memerr_d  = memerr_q;
        dmem_req  = 1'b0;
        Stall_Mem = 1'b0;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                Stall_Mem = access;
                if (access) begin
                    addr_d    = ALUResult_M;
                    wdata_d   = WriteData_M;
                    we_d      = MemWrite_M;
                    ctr_clear = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                dmem_req  = 1'b1;
                Stall_Mem = 1'b1;
                // Ack is checked first so a completion on the final wait cycle is not a timeout.
                if (dmem_ack) begin
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    state_d = DONE;
                end else if (ctr_expired) begin
                    memerr_d = 1'b1;
                    state_d  = ERR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                Stall_Mem = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            memerr_q <= memerr_d;
        end
    end

    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign ReadData_M = rdata_q;
    assign Bubble_W   = Stall_Mem;
    assign MemErr     = memerr_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - randomized self-checking bench with a transaction-level model
module tb_mem_access_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadData_M;
    logic        Stall_Mem;
    logic        Bubble_W;
    logic        MemErr;

    always #5 clk = ~clk;

    mem_access_sequencer #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWrite_M (MemWrite_M),
        .ResultSrc_M(ResultSrc_M),
        .ALUResult_M(ALUResult_M),
        .WriteData_M(WriteData_M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .ReadData_M (ReadData_M),
        .Stall_Mem  (Stall_Mem),
        .Bubble_W   (Bubble_W),
        .MemErr     (MemErr)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: one outstanding access, how long it has waited, whether it finished or trapped.
    bit          m_in_flight, m_finished, m_trapped;
    int          m_waited;
    bit          m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int          req_cnt, stall_cnt, req_pulses;
    logic        prev_req;
    logic [31:0] rd_obs;
    logic        we_obs, me_obs;
    bit          last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_flight = 0;
        m_finished  = 0;
        m_trapped   = 0;
        m_waited    = 0;
        m_we        = 0;
        m_addr      = '0;
        m_wdata     = '0;
        m_rdata     = '0;
        prev_req    = 1'b0;
        last_stall  = 0;
    endtask

    task automatic clr();
        req_cnt    = 0;
        stall_cnt  = 0;
        req_pulses = 0;
    endtask

    task automatic step(input logic mw, input logic [1:0] rs, input logic [31:0] a,
                        input logic [31:0] wd, input logic ack, input logic [31:0] rd);
        bit is_access, quiet, e_req, e_stall;
        @(negedge clk);
        MemWrite_M  = mw;
        ResultSrc_M = rs;
        ALUResult_M = a;
        WriteData_M = wd;
        dmem_ack    = ack;
        dmem_rdata  = rd;
        #1;
        is_access = mw || (rs == 2'b01);
        quiet     = !(m_in_flight || m_finished || m_trapped);
        e_req     = m_in_flight;
        e_stall   = m_in_flight || m_trapped || (quiet && is_access);
        chk("dmem_req", dmem_req, e_req);
        chk("Stall_Mem", Stall_Mem, e_stall);
        chk("Bubble_W", Bubble_W, e_stall);
        chk("MemErr", MemErr, m_trapped);
        chk("ReadData_M", ReadData_M, m_rdata);
        if (e_req) begin
            chk("dmem_addr", dmem_addr, m_addr);
            chk("dmem_wdata", dmem_wdata, m_wdata);
            chk("dmem_we", dmem_we, m_we);
            we_obs = dmem_we;
        end
        if (dmem_req) req_cnt++;
        if (Stall_Mem) stall_cnt++;
        if (dmem_req && !prev_req) req_pulses++;
        prev_req   = dmem_req;
        rd_obs     = ReadData_M;
        me_obs     = MemErr;
        last_stall = e_stall;
        // Advance the model to what the coming clock edge must produce.
        if (quiet && is_access) begin
            m_in_flight = 1;
            m_waited    = 0;
            m_addr      = a;
            m_wdata     = wd;
            m_we        = mw;
        end else if (m_in_flight) begin
            m_waited++;
            if (ack) begin
                if (!m_we) m_rdata = rd;
                m_in_flight = 0;
                m_finished  = 1;
            end else if (m_waited == TIMEOUT) begin
                m_in_flight = 0;
                m_trapped   = 1;
            end
        end else if (m_finished) begin
            m_finished = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b00;
        dmem_ack    = 1'b0;
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", Stall_Mem, 1'b0);
        chk("rst_memerr", MemErr, 1'b0);
        chk("rst_rdata", ReadData_M, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd1, rd2;
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b00;
        ALUResult_M = '0;
        WriteData_M = '0;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;
        rst_n       = 1'b0;
        model_reset();
        clr();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_stall", Stall_Mem, 1'b0);
        chk("reset_bubble", Bubble_W, 1'b0);
        chk("reset_memerr", MemErr, 1'b0);
        chk("reset_rdata", ReadData_M, 32'h0);
        chk("reset_we", dmem_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load with ack on the first BUSY cycle.
        clr();
        step(0, 2'b01, 32'h40, 32'h0, 0, 32'h0);
        step(0, 2'b01, 32'h40, 32'h0, 1, 32'hDEADBEEF);
        step(0, 2'b01, 32'h40, 32'h0, 0, 32'h0);
        chk("load_rdata_done", rd_obs, 32'hDEADBEEF);
        step(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
        chk("load_req_cycles", req_cnt, 1);
        chk("load_stall_cycles", stall_cnt, 2);

        // Store acked on its fifth BUSY cycle.
        clr();
        step(1, 2'b00, 32'h80, 32'h12345678, 0, 32'h0);
        repeat (4) step(1, 2'b00, 32'h80, 32'h12345678, 0, 32'hFFFFFFFF);
        step(1, 2'b00, 32'h80, 32'h12345678, 1, 32'hFFFFFFFF);
        step(1, 2'b00, 32'h80, 32'h12345678, 0, 32'h0);
        chk("store_rdata_kept", rd_obs, 32'hDEADBEEF);
        chk("store_we", we_obs, 1'b1);
        step(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
        chk("store_req_cycles", req_cnt, 5);
        chk("store_stall_cycles", stall_cnt, 6);

        // Timeout: no ack ever.
        clr();
        step(0, 2'b01, 32'h100, 32'h0, 0, 32'h0);
        repeat (TIMEOUT) step(0, 2'b01, 32'h100, 32'h0, 0, 32'h0);
        repeat (4) step(0, 2'b01, 32'h100, 32'h0, 0, 32'h0);
        chk("timeout_req_cycles", req_cnt, 16);
        chk("timeout_memerr", me_obs, 1'b1);
        chk("timeout_stall_cycles", stall_cnt, 21);
        do_reset();

        // Ack arriving on the final allowed wait cycle.
        clr();
        step(0, 2'b01, 32'h104, 32'h0, 0, 32'h0);
        repeat (TIMEOUT - 1) step(0, 2'b01, 32'h104, 32'h0, 0, 32'h0);
        step(0, 2'b01, 32'h104, 32'h0, 1, 32'hCAFEF00D);
        step(0, 2'b01, 32'h104, 32'h0, 0, 32'h0);
        chk("lateack_rdata", rd_obs, 32'hCAFEF00D);
        chk("lateack_memerr", me_obs, 1'b0);
        chk("lateack_req_cycles", req_cnt, 16);

        // Stray ack while idle.
        clr();
        step(0, 2'b00, 32'h0, 32'h0, 1, 32'hBAD0BAD0);
        step(0, 2'b10, 32'h0, 32'h0, 1, 32'hBAD0BAD1);
        step(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
        chk("stray_rdata", rd_obs, 32'hCAFEF00D);
        chk("stray_stall", stall_cnt, 0);

        // Asynchronous reset in the middle of a wait.
        step(0, 2'b01, 32'h200, 32'h0, 0, 32'h0);
        step(0, 2'b01, 32'h200, 32'h0, 0, 32'h0);
        step(0, 2'b01, 32'h200, 32'h0, 0, 32'h0);
        do_reset();
        step(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);

        // Two back-to-back loads.
        clr();
        step(0, 2'b01, 32'h300, 32'h0, 0, 32'h0);
        step(0, 2'b01, 32'h300, 32'h0, 1, 32'h11111111);
        step(0, 2'b01, 32'h300, 32'h0, 0, 32'h0);
        rd1 = rd_obs;
        step(0, 2'b01, 32'h304, 32'h0, 0, 32'h0);
        step(0, 2'b01, 32'h304, 32'h0, 1, 32'h22222222);
        step(0, 2'b01, 32'h304, 32'h0, 0, 32'h0);
        rd2 = rd_obs;
        step(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
        chk("b2b_rd1", rd1, 32'h11111111);
        chk("b2b_rd2", rd2, 32'h22222222);
        chk("b2b_req_pulses", req_pulses, 2);
        chk("b2b_stall_cycles", stall_cnt, 4);

        // Randomized instruction stream with variable memory latency.
        begin
            logic        r_mw, r_ack;
            logic [1:0]  r_rs;
            logic [31:0] r_a, r_wd;
            int          ack_pct, kind, sel;
            r_mw = 0; r_rs = 2'b00; r_a = '0; r_wd = '0; ack_pct = 50;
            for (int n = 0; n < 3000; n++) begin
                if ((m_trapped && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
                    do_reset();
                    last_stall = 0;
                    continue;
                end
                if (!last_stall) begin
                    kind = $urandom_range(0, 9);
                    r_a  = $urandom;
                    r_wd = $urandom;
                    if (kind <= 2) begin
                        sel  = $urandom_range(0, 2);
                        r_mw = 0;
                        r_rs = (sel == 0) ? 2'b00 : 2'(sel + 1);
                    end else if (kind <= 5) begin
                        r_mw = 0; r_rs = 2'b01;
                    end else if (kind <= 7) begin
                        r_mw = 1; r_rs = 2'b00;
                    end else if (kind == 8) begin
                        r_mw = 1; r_rs = 2'b01;
                    end else begin
                        r_mw = 1; r_rs = 2'(2 + $urandom_range(0, 1));
                    end
                    sel     = $urandom_range(0, 99);
                    ack_pct = (sel < 70) ? 50 : (sel < 95) ? 12 : 0;
                end
                r_ack = ($urandom_range(0, 99) < ack_pct);
                step(r_mw, r_rs, r_a, r_wd, r_ack, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
